// File: rtl/instr_fetch_reg_if.sv
// Fetch-stage bus between the PC stage/decode and the instruction fetch register.
interface instr_fetch_reg_if #(
    parameter int IW = 9,
    parameter int AW = 8
);
    logic          Start;
    logic [AW-1:0] PC;
    logic          Stall;
    logic          Flush;
    logic [IW-1:0] Instr;
    logic [AW-1:0] Instr_PC;
    logic          Instr_Valid;
    logic          Done;
    logic [15:0]   Fetch_Count;

    modport master (
        output Start, PC, Stall, Flush,
        input  Instr, Instr_PC, Instr_Valid, Done, Fetch_Count
    );

    modport slave (
        input  Start, PC, Stall, Flush,
        output Instr, Instr_PC, Instr_Valid, Done, Fetch_Count
    );
endinterface

// File: rtl/instr_fetch_reg.sv
// Instruction ROM plus fetch register with a 3-state run controller
// (start, stall hold, branch flush, HALT detection, issue counting).
module instr_fetch_reg #(
    parameter int                  IW        = 9,
    parameter int                  AW        = 8,
    parameter int                  DEPTH     = 256,
    parameter logic [IW-1:0]       NOP       = 9'h000,
    parameter logic [IW-1:0]       HALT_OP   = 9'h1FF,
    // Word i occupies bits [i*IW +: IW]; replaces the external ROM image file.
    parameter logic [DEPTH*IW-1:0] ROM_IMAGE = '0
) (
    input logic              CLK,
    input logic              Reset,
    instr_fetch_reg_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [IW-1:0] instr_q, instr_n;
    logic [AW-1:0] ipc_q, ipc_n;
    logic          valid_q, valid_n;
    logic          done_q, done_n;
    logic [15:0]   count_q, count_n;

    logic [IW-1:0] rom_word;
    logic          issue;
    int unsigned   addr;

    always_comb begin
        addr     = 32'(bus.PC);
        rom_word = NOP;
        if (addr < DEPTH) begin
            rom_word = ROM_IMAGE[addr*IW +: IW];
        end
    end

    assign issue = (state_q == RUN) && valid_q && !bus.Stall;

    always_comb begin
        state_n = state_q;
        instr_n = instr_q;
        ipc_n   = ipc_q;
        valid_n = valid_q;
        done_n  = done_q;
        count_n = count_q;

        if (bus.Start) begin
            state_n = RUN;
            instr_n = NOP;
            valid_n = 1'b0;
            done_n  = 1'b0;
            count_n = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_n = 1'b0;
                end
                RUN: begin
                    if (issue && count_q != 16'hFFFF) begin
                        count_n = count_q + 16'd1;
                    end
                    // An issuing HALT outranks flush/fetch: anything behind it is dropped.
                    if (issue && instr_q == HALT_OP) begin
                        state_n = HALT;
                        done_n  = 1'b1;
                        valid_n = 1'b0;
                        instr_n = NOP;
                    end else if (bus.Flush) begin
                        instr_n = NOP;
                        ipc_n   = bus.PC;
                        valid_n = 1'b0;
                    end else if (!bus.Stall) begin
                        instr_n = rom_word;
                        ipc_n   = bus.PC;
                        valid_n = 1'b1;
                    end
                end
                HALT: begin
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            instr_q <= NOP;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            instr_q <= instr_n;
            ipc_q   <= ipc_n;
            valid_q <= valid_n;
            done_q  <= done_n;
            count_q <= count_n;
        end
    end

    assign bus.Instr       = instr_q;
    assign bus.Instr_PC    = ipc_q;
    assign bus.Instr_Valid = valid_q;
    assign bus.Done        = done_q;
    assign bus.Fetch_Count = count_q;
endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed table-driven bench for instr_fetch_reg with a 64-word ROM image.
module tb_instr_fetch_reg;
    localparam int IW    = 9;
    localparam int AW    = 8;
    localparam int DEPTH = 64;

    // ROM[0..3] = 011,022,033,1FF; ROM[i] = 9'h100|i for i >= 4.
    function automatic logic [DEPTH*IW-1:0] make_img();
        logic [DEPTH*IW-1:0] img;
        logic [IW-1:0]       w;
        img = '0;
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       w = 9'h011;
                1:       w = 9'h022;
                2:       w = 9'h033;
                3:       w = 9'h1FF;
                default: w = 9'h100 | 9'(i);
            endcase
            img[i*IW +: IW] = w;
        end
        return img;
    endfunction

    localparam logic [DEPTH*IW-1:0] IMG = make_img();

    logic clk;
    logic rst;
    int   total;
    int   bad;

    instr_fetch_reg_if #(.IW(IW), .AW(AW)) bus ();

    instr_fetch_reg #(
        .IW(IW), .AW(AW), .DEPTH(DEPTH),
        .NOP(9'h000), .HALT_OP(9'h1FF), .ROM_IMAGE(IMG)
    ) dut (
        .CLK(clk),
        .Reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [7:0]  pc;
        logic        stall;
        logic        flush;
        logic [8:0]  e_instr;
        logic [7:0]  e_pc;
        logic        e_valid;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(logic s, logic [7:0] p, logic st, logic fl,
                                logic [8:0] ei, logic [7:0] ep, logic ev,
                                logic ed, logic [15:0] ec);
        vec_t v;
        v.start = s; v.pc = p; v.stall = st; v.flush = fl;
        v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_done = ed; v.e_cnt = ec;
        return v;
    endfunction

    task automatic step(input logic s, input logic [7:0] p, input logic st, input logic fl);
        bus.Start = s;
        bus.PC    = p;
        bus.Stall = st;
        bus.Flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] ei, input logic [7:0] ep,
                       input logic ev, input logic ed, input logic [15:0] ec);
        total += 5;
        if (bus.Instr !== ei) begin
            bad++;
            $display("FAIL %s instr got=%h want=%h", name, bus.Instr, ei);
        end
        if (bus.Instr_PC !== ep) begin
            bad++;
            $display("FAIL %s instr_pc got=%h want=%h", name, bus.Instr_PC, ep);
        end
        if (bus.Instr_Valid !== ev) begin
            bad++;
            $display("FAIL %s valid got=%b want=%b", name, bus.Instr_Valid, ev);
        end
        if (bus.Done !== ed) begin
            bad++;
            $display("FAIL %s done got=%b want=%b", name, bus.Done, ed);
        end
        if (bus.Fetch_Count !== ec) begin
            bad++;
            $display("FAIL %s count got=%0d want=%0d", name, bus.Fetch_Count, ec);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.Start = 1'b0; bus.PC = '0; bus.Stall = 1'b0; bus.Flush = 1'b0;

        //            start pc     st  fl   instr   ipc    v  d  cnt
        vecs[0]  = mk(1, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0);  // start
        vecs[1]  = mk(0, 8'h00, 0, 0, 9'h011, 8'h00, 1, 0, 0);
        vecs[2]  = mk(0, 8'h01, 0, 0, 9'h022, 8'h01, 1, 0, 1);
        vecs[3]  = mk(0, 8'h02, 0, 0, 9'h033, 8'h02, 1, 0, 2);
        vecs[4]  = mk(0, 8'h03, 0, 0, 9'h1FF, 8'h03, 1, 0, 3);
        vecs[5]  = mk(0, 8'h04, 0, 0, 9'h000, 8'h03, 0, 1, 4);  // HALT issued
        vecs[6]  = mk(0, 8'h05, 0, 0, 9'h000, 8'h03, 0, 1, 4);  // PC ignored
        vecs[7]  = mk(1, 8'h05, 0, 0, 9'h000, 8'h03, 0, 0, 0);  // restart
        vecs[8]  = mk(0, 8'h05, 0, 0, 9'h105, 8'h05, 1, 0, 0);
        vecs[9]  = mk(0, 8'h06, 1, 0, 9'h105, 8'h05, 1, 0, 0);  // stall x3
        vecs[10] = mk(0, 8'h06, 1, 0, 9'h105, 8'h05, 1, 0, 0);
        vecs[11] = mk(0, 8'h06, 1, 0, 9'h105, 8'h05, 1, 0, 0);
        vecs[12] = mk(0, 8'h06, 0, 0, 9'h106, 8'h06, 1, 0, 1);
        vecs[13] = mk(0, 8'h07, 1, 1, 9'h000, 8'h07, 0, 0, 1);  // flush+stall
        vecs[14] = mk(0, 8'h20, 0, 0, 9'h120, 8'h20, 1, 0, 1);
        vecs[15] = mk(0, 8'h21, 0, 0, 9'h121, 8'h21, 1, 0, 2);
        vecs[16] = mk(0, 8'h50, 0, 0, 9'h000, 8'h50, 1, 0, 3);  // out of range
        vecs[17] = mk(0, 8'hFF, 0, 0, 9'h000, 8'hFF, 1, 0, 4);
        vecs[18] = mk(0, 8'h00, 0, 0, 9'h011, 8'h00, 1, 0, 5);  // wrap
        vecs[19] = mk(0, 8'h01, 0, 1, 9'h000, 8'h01, 0, 0, 6);  // flush, issue
        vecs[20] = mk(0, 8'h04, 0, 0, 9'h104, 8'h04, 1, 0, 6);
        vecs[21] = mk(0, 8'h03, 0, 0, 9'h1FF, 8'h03, 1, 0, 7);
        vecs[22] = mk(0, 8'h04, 1, 0, 9'h1FF, 8'h03, 1, 0, 7);  // stalled HALT
        vecs[23] = mk(0, 8'h04, 0, 0, 9'h000, 8'h03, 0, 1, 8);

        // Reset with random other inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            chk("reset", 9'h000, 8'h00, 0, 0, 0);
        end
        rst = 1'b0;
        step(0, 8'h09, 0, 0);
        chk("idle", 9'h000, 8'h00, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].start, vecs[i].pc, vecs[i].stall, vecs[i].flush);
            chk($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc,
                vecs[i].e_valid, vecs[i].e_done, vecs[i].e_cnt);
        end

        // Reset mid-RUN after 10 issues
        step(1, 8'h04, 0, 0);
        for (int p = 4; p <= 14; p++) step(0, 8'(p), 0, 0);
        chk("run10", 9'h10E, 8'h0E, 1, 0, 10);
        rst = 1'b1;
        step(0, 8'h0F, 0, 0);
        chk("midrst", 9'h000, 8'h00, 0, 0, 0);
        rst = 1'b0;
        step(0, 8'h0F, 0, 0);
        chk("postrst", 9'h000, 8'h00, 0, 0, 0);

        // Reach HALT, then Start from HALT
        step(1, 8'h00, 0, 0);
        for (int p = 0; p <= 4; p++) step(0, 8'(p), 0, 0);
        chk("halt2", 9'h000, 8'h03, 0, 1, 4);
        step(1, 8'h00, 0, 0);
        chk("restart", 9'h000, 8'h03, 0, 0, 0);
        step(0, 8'h00, 0, 0);
        chk("refetch", 9'h011, 8'h00, 1, 0, 0);
        step(0, 8'h01, 0, 0);
        chk("refetch2", 9'h022, 8'h01, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
